// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe move sequencer.
//   state_t      - sequencer FSM states
//   WIN_*        - encoding of the winner output
//   FULL_BOARD   - occupancy value of a completely filled board
//   LINE_MASK    - the eight winning lines, indexed in win_line bit order:
//                  rows 876, 543, 210; cols 852, 741, 630; diag 840; diag 246
//   square_bit() - one-hot square select from a 4-bit position (0 for 9..15)
package ttt_pkg;

    typedef enum logic [1:0] {
        PLAY_A = 2'd0,
        PLAY_B = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [8:0] FULL_BOARD = 9'h1FF;

    localparam logic [8:0] LINE_MASK [0:7] = '{
        9'h1C0,  // row 8 7 6
        9'h038,  // row 5 4 3
        9'h007,  // row 2 1 0
        9'h124,  // col 8 5 2
        9'h092,  // col 7 4 1
        9'h049,  // col 6 3 0
        9'h111,  // diag 8 4 0
        9'h054   // diag 2 4 6
    };

    // Positions above 8 shift the single bit out of the 9-bit result,
    // so an out-of-range position selects no square.
    function automatic logic [8:0] square_bit(input logic [3:0] pos);
        logic [8:0] sel;
        sel = 9'd1 << pos;
        return sel;
    endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: combinational win-line evaluator for one player's vector.
// A line is reported when all three of its squares are held; extra pieces
// elsewhere on the board do not matter.
//   vec  in  9 : squares held by one player (bit = square index 8..0)
//   line out 8 : bit i set when LINE_MASK[i] is fully covered by vec
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [8:0] vec,
    output logic [7:0] line
);

    always_comb begin
        line = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            line[i] = ((vec & LINE_MASK[i]) == LINE_MASK[i]);
        end
    end

endmodule

// File: rtl/ttt_move_sequencer.sv
// ttt_move_sequencer: accepts alternating player moves over a valid/ready
// handshake, maintains the A/B occupancy vectors, checks each move for a
// win or draw and reports the final result.
//
// Build option: define INTERNAL_DETECT_EN to detect lines internally with
// ttt_line_eval on the mover's vector; otherwise the external win_line
// input (driven by a detector watching ain/bin) is used as-is.
//
// Ports:
//   clk        in  1 : rising-edge clock
//   rst_n      in  1 : asynchronous active-low reset
//   new_game   in  1 : synchronous clear of board and result, A to move
//   move_valid in  1 : a move is offered on move_pos
//   move_pos   in  4 : square index 0..8 (9..15 illegal)
//   move_ready out 1 : a move can be accepted this cycle
//   win_line   in  8 : one-hot line code from the external detector
//   ain        out 9 : squares held by player A
//   bin        out 9 : squares held by player B
//   turn_b     out 1 : 0 = A to move / last mover A, 1 = B
//   illegal    out 1 : one-cycle pulse after a rejected move
//   game_over  out 1 : high while the game is finished
//   winner     out 2 : 00 none, 01 A, 10 B, 11 draw
//   final_line out 8 : line code captured at the win, 0 for a draw
module ttt_move_sequencer
    import ttt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    input  logic [7:0] win_line,
    output logic [8:0] ain,
    output logic [8:0] bin,
    output logic       turn_b,
    output logic       illegal,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [7:0] final_line
);

    state_t     state;
    logic [8:0] occupied;
    logic [8:0] pos_bit;
    logic       legal;
    logic [7:0] line_hit;

    always_comb begin
        occupied = ain | bin;
        pos_bit  = square_bit(move_pos);
        legal    = (move_pos <= 4'd8) && ((occupied & pos_bit) == '0);
    end

`ifdef INTERNAL_DETECT_EN
    logic [8:0] mover_vec;
    logic [7:0] internal_line;
    logic       unused_win_line;

    always_comb begin
        mover_vec       = turn_b ? bin : ain;
        line_hit        = internal_line;
        unused_win_line = ^win_line;
    end

    ttt_line_eval u_line_eval (
        .vec  (mover_vec),
        .line (internal_line)
    );
`else
    always_comb begin
        line_hit = win_line;
    end
`endif

    always_comb begin
        move_ready = (state == PLAY_A) || (state == PLAY_B);
        game_over  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PLAY_A;
            ain        <= '0;
            bin        <= '0;
            turn_b     <= 1'b0;
            illegal    <= 1'b0;
            winner     <= WIN_NONE;
            final_line <= '0;
        end else begin
            illegal <= 1'b0;
            if (new_game) begin
                state      <= PLAY_A;
                ain        <= '0;
                bin        <= '0;
                turn_b     <= 1'b0;
                winner     <= WIN_NONE;
                final_line <= '0;
            end else begin
                case (state)
                    PLAY_A, PLAY_B: begin
                        if (move_valid) begin
                            if (legal) begin
                                if (state == PLAY_B) begin
                                    bin <= bin | pos_bit;
                                end else begin
                                    ain <= ain | pos_bit;
                                end
                                turn_b <= (state == PLAY_B);
                                state  <= CHECK;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        // A win takes precedence over a full board, so a
                        // winning ninth move reports the winner.
                        if (line_hit != '0) begin
                            winner     <= turn_b ? WIN_B : WIN_A;
                            final_line <= line_hit;
                            state      <= DONE;
                        end else if (occupied == FULL_BOARD) begin
                            winner <= WIN_DRAW;
                            state  <= DONE;
                        end else begin
                            turn_b <= ~turn_b;
                            state  <= turn_b ? PLAY_A : PLAY_B;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= PLAY_A;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Scoreboard bench for ttt_move_sequencer: a game model built from the
// rules of tic-tac-toe predicts each move's outcome; a monitor compares
// the DUT's response whenever it reports a rejected move or finishes a check.
module tb_ttt_move_sequencer;

    typedef struct {
        bit         is_illegal;
        logic [8:0] ain;
        logic [8:0] bin;
        logic       turn_b;
        logic       game_over;
        logic       move_ready;
        logic [1:0] winner;
        logic [7:0] final_line;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic [3:0] move_pos = '0;
    logic       move_ready;
    logic [7:0] win_line;
    logic [8:0] ain;
    logic [8:0] bin;
    logic       turn_b;
    logic       illegal;
    logic       game_over;
    logic [1:0] winner;
    logic [7:0] final_line;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit was_check = 1'b0;
    exp_t q[$];

    // Winning lines as square triplets, in win_line bit order.
    int unsigned tri_sq [0:7][0:2] = '{
        '{8, 7, 6}, '{5, 4, 3}, '{2, 1, 0},
        '{8, 5, 2}, '{7, 4, 1}, '{6, 3, 0},
        '{8, 4, 0}, '{2, 4, 6}
    };

    // Game model
    logic [8:0] ma, mb;
    bit         m_mover;
    bit         m_over;
    logic [1:0] m_winner;
    logic [7:0] m_final;

    ttt_move_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .move_ready (move_ready),
        .win_line   (win_line),
        .ain        (ain),
        .bin        (bin),
        .turn_b     (turn_b),
        .illegal    (illegal),
        .game_over  (game_over),
        .winner     (winner),
        .final_line (final_line)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lines_of(input logic [8:0] v);
        logic [7:0] code;
        code = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[tri_sq[i][0]] && v[tri_sq[i][1]] && v[tri_sq[i][2]]) code[i] = 1'b1;
        end
        return code;
    endfunction

    // External detector environment: reports any completed line on the board.
    always_comb begin
        win_line = lines_of(ain) | lines_of(bin);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ma = '0; mb = '0; m_mover = 1'b0; m_over = 1'b0;
        m_winner = 2'b00; m_final = '0;
    endtask

    task automatic compare_rec(input exp_t e, input bit obs_illegal);
        chk("event_kind", obs_illegal, e.is_illegal);
        chk("ain", ain, e.ain);
        chk("bin", bin, e.bin);
        chk("turn_b", turn_b, e.turn_b);
        chk("game_over", game_over, e.game_over);
        chk("move_ready", move_ready, e.move_ready);
        chk("winner", winner, e.winner);
        chk("final_line", final_line, e.final_line);
    endtask

    // Monitor: pops an expectation on every illegal pulse and at the end of
    // every check cycle.
    always @(negedge clk) begin
        bit   cur_check;
        exp_t e;
        if (!mon_en) begin
            was_check = 1'b0;
        end else begin
            chk("no_shared_square", ain & bin, 9'h000);
            if (illegal) begin
                if (q.size() == 0) begin
                    chk("spurious_illegal", 1, 0);
                end else begin
                    e = q.pop_front();
                    compare_rec(e, 1'b1);
                end
            end
            cur_check = !move_ready && !game_over;
            if (was_check && !cur_check) begin
                if (q.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    compare_rec(e, 1'b0);
                end
            end
            was_check = cur_check;
        end
    end

    task automatic predict(input int pos);
        exp_t       e;
        logic [7:0] code;
        if (m_over) return;
        if (pos > 8 || ((ma | mb) >> pos) & 9'd1) begin
            e.is_illegal = 1'b1;
        end else begin
            e.is_illegal = 1'b0;
            if (m_mover) mb[pos] = 1'b1; else ma[pos] = 1'b1;
            code = lines_of(m_mover ? mb : ma);
            if (code != '0) begin
                m_over = 1'b1; m_winner = m_mover ? 2'b10 : 2'b01; m_final = code;
            end else if ((ma | mb) == 9'h1FF) begin
                m_over = 1'b1; m_winner = 2'b11;
            end else begin
                m_mover = !m_mover;
            end
        end
        e.ain = ma; e.bin = mb; e.turn_b = m_mover;
        e.game_over = m_over; e.move_ready = !m_over;
        e.winner = m_winner; e.final_line = m_final;
        q.push_back(e);
    endtask

    // Called at posedge+1; offers one move for one cycle and waits for the
    // expected response to be consumed.
    task automatic do_move(input int pos);
        bit expect_resp;
        expect_resp = !m_over;
        predict(pos);
        move_valid = 1'b1;
        move_pos   = 4'(pos);
        @(posedge clk); #1;
        move_valid = 1'b0;
        if (expect_resp) begin
            for (int n = 0; n < 8 && q.size() != 0; n++) begin
                @(posedge clk); #1;
            end
            chk("response_timeout", q.size(), 0);
            q.delete();
        end else begin
            repeat (3) begin
                @(posedge clk); #1;
                chk("done_no_illegal", illegal, 1'b0);
            end
        end
    endtask

    task automatic start_game(input bit with_move, input int pos);
        new_game   = 1'b1;
        move_valid = with_move;
        move_pos   = 4'(pos);
        @(posedge clk); #1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        model_reset();
        chk("ng_ain", ain, 9'h000);
        chk("ng_bin", bin, 9'h000);
        chk("ng_turn_b", turn_b, 1'b0);
        chk("ng_winner", winner, 2'b00);
        chk("ng_final", final_line, 8'h00);
        chk("ng_game_over", game_over, 1'b0);
        chk("ng_move_ready", move_ready, 1'b1);
        chk("ng_illegal", illegal, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ain"}, ain, 9'h000);
        chk({tag, "_bin"}, bin, 9'h000);
        chk({tag, "_turn_b"}, turn_b, 1'b0);
        chk({tag, "_illegal"}, illegal, 1'b0);
        chk({tag, "_game_over"}, game_over, 1'b0);
        chk({tag, "_winner"}, winner, 2'b00);
        chk({tag, "_final"}, final_line, 8'h00);
        chk({tag, "_move_ready"}, move_ready, 1'b1);
    endtask

    initial begin
        int pos;
        int empt[$];
        int cnt;
        model_reset();
        #12;
        check_reset_values("reset");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Legal alternation
        start_game(0, 0);
        do_move(4); do_move(0); do_move(8);
        chk("alt_ain", ain, 9'h110);
        chk("alt_bin", bin, 9'h001);
        chk("alt_turn_b", turn_b, 1'b1);

        // Occupied square, then out-of-range, then a legal retry
        start_game(0, 0);
        do_move(4); do_move(4); do_move(12); do_move(5);

        // Row win, then a move in DONE is ignored
        start_game(0, 0);
        do_move(8); do_move(0); do_move(7); do_move(1); do_move(6);
        chk("row_final", final_line, 8'h01);
        do_move(3);

        // new_game together with a move while DONE: move is dropped
        start_game(1, 4);
        @(posedge clk); #1;
        chk("ng_drop_ain", ain, 9'h000);

        // Draw
        do_move(4); do_move(0); do_move(8); do_move(2); do_move(1);
        do_move(7); do_move(6); do_move(3); do_move(5);
        chk("draw_board", ain | bin, 9'h1FF);
        chk("draw_winner", winner, 2'b11);

        // Asynchronous reset while in CHECK
        start_game(0, 0);
        mon_en = 1'b0;
        move_valid = 1'b1; move_pos = 4'd4;
        @(posedge clk); #1;
        move_valid = 1'b0;
        chk("in_check_ready", move_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        q.delete();
        mon_en = 1'b1;

        // Randomized games
        for (int g = 0; g < 30; g++) begin
            start_game(($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
            cnt = 0;
            while (!m_over && cnt < 40) begin
                if ($urandom_range(0, 99) < 15) begin
                    pos = int'($urandom_range(0, 15));
                end else begin
                    empt.delete();
                    for (int i = 0; i < 9; i++) if (!(ma[i] | mb[i])) empt.push_back(i);
                    pos = empt[$urandom_range(0, empt.size() - 1)];
                end
                do_move(pos);
                cnt++;
            end
            if ($urandom_range(0, 1) == 1) do_move(int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
